// File: rtl/dma_copy_engine.sv
// CSR-programmed burst copy: Avalon-MM read burst into a local buffer, then write burst out,
// with an optional printable-byte filter on the write path and a sticky done/irq.
module dma_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_AW     = 12,
  parameter int BURST_W    = BUF_AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            avs_csr_address,
  input  logic                  avs_csr_write,
  input  logic [31:0]           avs_csr_writedata,
  input  logic                  avs_csr_read,
  output logic [31:0]           avs_csr_readdata,
  input  logic                  avm_rx_waitrequest,
  output logic [BURST_W-1:0]    avm_rx_burstcount,
  output logic [31:0]           avm_rx_address,
  output logic                  avm_rx_read,
  input  logic [DATA_WIDTH-1:0] avm_rx_readdata,
  input  logic                  avm_rx_readdatavalid,
  input  logic                  avm_tx_waitrequest,
  output logic [BURST_W-1:0]    avm_tx_burstcount,
  output logic [31:0]           avm_tx_address,
  output logic                  avm_tx_write,
  output logic [DATA_WIDTH-1:0] avm_tx_writedata,
  output logic                  irq
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR      = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam int         NB        = DATA_WIDTH / 8;
  localparam logic [BURST_W-1:0] ONE     = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] MAX_LEN = ONE << BUF_AW;

  function automatic logic [7:0] filt_byte(input logic [7:0] b, input logic en, input logic [7:0] fill);
    if (en && !((b == 8'h0A) || ((b >= 8'h20) && (b <= 8'h7E)))) begin
      filt_byte = fill;
    end else begin
      filt_byte = b;
    end
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  filter_en_q, filter_en_d, irq_en_q, irq_en_d;
  logic                  error_q, error_d, done_q, done_d;
  logic [31:0]           src_q, src_d, dst_q, dst_d, xsrc_q, xsrc_d, xdst_q, xdst_d;
  logic [BURST_W-1:0]    len_q, len_d, xlen_q, xlen_d;
  logic [BURST_W-1:0]    rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic                  xfilt_q, xfilt_d;
  logic [7:0]            fill_q, fill_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] buf_q [2**BUF_AW];

  logic                  ctl_wr_s, start_req_s, clrerr_s, len_ok_s, start_ok_s;
  logic                  rx_acc_s, rx_cap_s, tx_acc_s;
  logic [DATA_WIDTH-1:0] buf_rd_s, wdata_s;

  assign ctl_wr_s    = avs_csr_write && (avs_csr_address == 3'd0);
  assign start_req_s = ctl_wr_s && avs_csr_writedata[0];
  assign clrerr_s    = ctl_wr_s && avs_csr_writedata[1];
  assign len_ok_s    = (len_q != {BURST_W{1'b0}}) && (len_q <= MAX_LEN);
  assign start_ok_s  = start_req_s && !clrerr_s && (state_q == S_IDLE) && !error_q && len_ok_s;
  assign rx_acc_s    = (state_q == S_RD_REQ) && !avm_rx_waitrequest;
  assign rx_cap_s    = ((state_q == S_RD_REQ) || (state_q == S_RD_DATA)) && avm_rx_readdatavalid
                       && (rd_idx_q != xlen_q);
  assign tx_acc_s    = (state_q == S_WR) && !avm_tx_waitrequest;
  assign buf_rd_s    = buf_q[wr_idx_q[BUF_AW-1:0]];

  // Byte-lane filter on the buffer read feeding the write master
  always_comb begin
    wdata_s = buf_rd_s;
    for (int i = 0; i < NB; i++) begin
      wdata_s[i*8 +: 8] = filt_byte(buf_rd_s[i*8 +: 8], xfilt_q, fill_q);
    end
  end

  assign avm_rx_read       = (state_q == S_RD_REQ);
  assign avm_rx_address    = avm_rx_read ? xsrc_q : 32'd0;
  assign avm_rx_burstcount = avm_rx_read ? xlen_q : {BURST_W{1'b0}};
  assign avm_tx_write      = (state_q == S_WR);
  assign avm_tx_address    = avm_tx_write ? xdst_q : 32'd0;
  assign avm_tx_burstcount = avm_tx_write ? xlen_q : {BURST_W{1'b0}};
  assign avm_tx_writedata  = avm_tx_write ? wdata_s : {DATA_WIDTH{1'b0}};
  assign avs_csr_readdata  = rdata_q;
  assign irq               = done_q && irq_en_q;

  // Next-state logic for the CSR file and transfer FSM
  always_comb begin
    state_d     = state_q;
    filter_en_d = filter_en_q;
    irq_en_d    = irq_en_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    fill_d      = fill_q;
    xsrc_d      = xsrc_q;
    xdst_d      = xdst_q;
    xlen_d      = xlen_q;
    xfilt_d     = xfilt_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rx_cap_s ? (rd_idx_q + ONE) : rd_idx_q;
    rdata_d     = 32'd0;

    if (avs_csr_write) begin
      case (avs_csr_address)
        3'd0: begin
          filter_en_d = avs_csr_writedata[2];
          irq_en_d    = avs_csr_writedata[3];
        end
        3'd2:    src_d  = avs_csr_writedata;
        3'd3:    dst_d  = avs_csr_writedata;
        3'd4:    len_d  = avs_csr_writedata[BURST_W-1:0];
        3'd5:    fill_d = avs_csr_writedata[7:0];
        default: ;
      endcase
    end else begin
      len_d = len_q;
    end

    if (avs_csr_read) begin
      case (avs_csr_address)
        3'd0:    rdata_d = {28'd0, irq_en_q, filter_en_q, 2'd0};
        3'd1:    rdata_d = {29'd0, done_q, error_q, (state_q != S_IDLE)};
        3'd2:    rdata_d = src_q;
        3'd3:    rdata_d = dst_q;
        3'd4:    rdata_d = 32'(len_q);
        3'd5:    rdata_d = {24'd0, fill_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end

    if (clrerr_s) begin
      error_d = 1'b0;
    end else if (start_req_s && !start_ok_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end

    // Completion set takes priority over a coincident write-1-to-clear
    if (state_q == S_DONE) begin
      done_d = 1'b1;
    end else if (start_ok_s) begin
      done_d = 1'b0;
    end else if (avs_csr_write && (avs_csr_address == 3'd1) && avs_csr_writedata[2]) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_ok_s) begin
          state_d  = S_RD_REQ;
          xsrc_d   = src_q;
          xdst_d   = dst_q;
          xlen_d   = len_q;
          xfilt_d  = avs_csr_writedata[2];
          rd_idx_d = {BURST_W{1'b0}};
          wr_idx_d = {BURST_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_REQ: begin
        if (rx_acc_s) begin
          state_d = S_RD_DATA;
        end else begin
          state_d = S_RD_REQ;
        end
      end
      S_RD_DATA: begin
        if (rd_idx_d == xlen_q) begin
          state_d = S_WR;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_WR: begin
        if (tx_acc_s) begin
          wr_idx_d = wr_idx_q + ONE;
          state_d  = ((wr_idx_q + ONE) == xlen_q) ? S_DONE : S_WR;
        end else begin
          state_d = S_WR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control/status registers and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      filter_en_q <= 1'b0;
      irq_en_q    <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      len_q       <= {BURST_W{1'b0}};
      fill_q      <= 8'h20;
      xsrc_q      <= 32'd0;
      xdst_q      <= 32'd0;
      xlen_q      <= {BURST_W{1'b0}};
      xfilt_q     <= 1'b0;
      rd_idx_q    <= {BURST_W{1'b0}};
      wr_idx_q    <= {BURST_W{1'b0}};
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      filter_en_q <= filter_en_d;
      irq_en_q    <= irq_en_d;
      error_q     <= error_d;
      done_q      <= done_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      fill_q      <= fill_d;
      xsrc_q      <= xsrc_d;
      xdst_q      <= xdst_d;
      xlen_q      <= xlen_d;
      xfilt_q     <= xfilt_d;
      rd_idx_q    <= rd_idx_d;
      wr_idx_q    <= wr_idx_d;
      rdata_q     <= rdata_d;
    end
  end

  // Burst buffer; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (rx_cap_s) begin
      buf_q[rd_idx_q[BUF_AW-1:0]] <= avm_rx_readdata;
    end
  end

endmodule
